// File: rtl/dsp_mac_scheduler.sv
// Round-robin scheduler sharing one fixed-latency DSP multiply-add slice among NREQ requesters.
// Keeps a per-requester accumulator and blocks a MAC until that requester has nothing in flight.
module dsp_mac_scheduler #(
  parameter int NREQ = 4,
  parameter int LAT  = 3,
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                clk_i,
  input  logic                srst_i,
  input  logic [NREQ-1:0]     req_valid_i,
  output logic [NREQ-1:0]     req_ready_o,
  input  logic [NREQ*18-1:0]  req_a_i,
  input  logic [NREQ*18-1:0]  req_b_i,
  input  logic [NREQ*2-1:0]   req_op_i,
  output logic [17:0]         dsp_a_o,
  output logic [17:0]         dsp_b_o,
  output logic [39:0]         dsp_c_o,
  output logic                dsp_en_o,
  input  logic [39:0]         dsp_p_i,
  output logic                res_valid_o,
  output logic [IDW-1:0]      res_id_o,
  output logic [39:0]         res_data_o
);

  localparam logic [1:0] OP_MAC  = 2'b01;
  localparam logic [1:0] OP_LOAD = 2'b10;
  localparam int CW = $clog2(LAT + 3);

  logic [IDW-1:0] ptr_q;
  logic [39:0]    acc_q    [NREQ];
  logic [CW-1:0]  outst_q  [NREQ];
  logic [CW-1:0]  outst_d  [NREQ];
  logic           tagValid_q [LAT+1];
  logic [IDW-1:0] tagId_q    [LAT+1];
  logic [1:0]     tagOp_q    [LAT+1];
  logic [17:0]    dspA_q, dspB_q;
  logic [39:0]    dspC_q;
  logic           dspEn_q;
  logic           resValid_q;
  logic [IDW-1:0] resId_q;
  logic [39:0]    resData_q;

  logic [NREQ-1:0] eligible;
  logic            grantValid;
  logic [IDW-1:0]  grantId;
  logic [17:0]     selA, selB;
  logic [1:0]      selOp;
  logic            retire;
  int              idxInt;

  // A requester counts as busy while any of its operations is still in the tag pipeline.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NREQ; i++) begin
      eligible[i] = req_valid_i[i] && !srst_i &&
                    !((req_op_i[2*i +: 2] == OP_MAC) && (outst_q[i] != '0));
    end
  end

  always_comb begin
    grantValid = 1'b0;
    grantId    = '0;
    idxInt     = 0;
    for (int k = 0; k < NREQ; k++) begin
      idxInt = int'(ptr_q) + k;
      if (idxInt >= NREQ) idxInt = idxInt - NREQ;
      if (!grantValid && eligible[IDW'(idxInt)]) begin
        grantValid = 1'b1;
        grantId    = IDW'(idxInt);
      end
    end
  end

  always_comb begin
    req_ready_o = '0;
    if (grantValid) req_ready_o[grantId] = 1'b1;
  end

  assign selA   = req_a_i[18*grantId +: 18];
  assign selB   = req_b_i[18*grantId +: 18];
  assign selOp  = req_op_i[2*grantId +: 2];
  assign retire = tagValid_q[LAT];

  // An issue and a retire of the same requester on one edge cancel out.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      outst_d[i] = outst_q[i]
                 + CW'(grantValid && (grantId == IDW'(i)))
                 - CW'(retire && (tagId_q[LAT] == IDW'(i)));
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      ptr_q      <= '0;
      dspA_q     <= '0;
      dspB_q     <= '0;
      dspC_q     <= '0;
      dspEn_q    <= 1'b0;
      resValid_q <= 1'b0;
      resId_q    <= '0;
      resData_q  <= '0;
      for (int i = 0; i < NREQ; i++) begin
        acc_q[i]   <= '0;
        outst_q[i] <= '0;
      end
      for (int k = 0; k <= LAT; k++) begin
        tagValid_q[k] <= 1'b0;
        tagId_q[k]    <= '0;
        tagOp_q[k]    <= '0;
      end
    end else begin
      dspEn_q <= grantValid;
      if (grantValid) begin
        dspA_q <= selA;
        dspB_q <= selB;
        dspC_q <= (selOp == OP_MAC) ? acc_q[grantId] : '0;
        ptr_q  <= (grantId == IDW'(NREQ - 1)) ? '0 : grantId + 1'b1;
      end
      tagValid_q[0] <= grantValid;
      tagId_q[0]    <= grantId;
      tagOp_q[0]    <= selOp;
      for (int k = 1; k <= LAT; k++) begin
        tagValid_q[k] <= tagValid_q[k-1];
        tagId_q[k]    <= tagId_q[k-1];
        tagOp_q[k]    <= tagOp_q[k-1];
      end
      // The last tag stage lines up with the cycle in which DSP_P holds that issue's result.
      resValid_q <= retire;
      if (retire) begin
        resId_q   <= tagId_q[LAT];
        resData_q <= dsp_p_i;
        if ((tagOp_q[LAT] == OP_MAC) || (tagOp_q[LAT] == OP_LOAD)) begin
          acc_q[tagId_q[LAT]] <= dsp_p_i;
        end
      end
      for (int i = 0; i < NREQ; i++) begin
        outst_q[i] <= outst_d[i];
      end
    end
  end

  assign dsp_a_o     = dspA_q;
  assign dsp_b_o     = dspB_q;
  assign dsp_c_o     = dspC_q;
  assign dsp_en_o    = dspEn_q;
  assign res_valid_o = resValid_q;
  assign res_id_o    = resId_q;
  assign res_data_o  = resData_q;

endmodule

// File: doc/dsp_mac_scheduler.md
DSP_MAC_SCHEDULER -- requirements
Module: dsp_mac_scheduler

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing one MAE DSP slice; IDW = clog2(NREQ).
REQ-002 Parameter LAT, default 3: fixed DSP latency in cycles, from DSP_A/B/C being presented to DSP_P being valid; range 1..6.
REQ-003 CLK  in  1  the only clock; all state changes on its rising edge.
REQ-004 SRST  in  1  synchronous, active-high reset.
REQ-005 REQ_VALID  in  NREQ  per-requester operation request.
REQ-006 REQ_READY  out  NREQ  per-requester accept; a handshake completes when VALID and READY are both high in a cycle.
REQ-007 REQ_A, REQ_B  in  NREQ*18 each  signed operands; requester i uses slice [18i+17:18i].
REQ-008 REQ_OP  in  NREQ*2  per-requester opcode: 00 MUL, 01 MAC, 10 LOAD, 11 reserved.
REQ-009 DSP_A, DSP_B  out  18 each  operands to the shared DSP.
REQ-010 DSP_C  out  40  addend to the shared DSP.
REQ-011 DSP_EN  out  1  high when DSP_A/B/C carry an issued operation.
REQ-012 DSP_P  in  40  DSP result, equal to DSP_A*DSP_B+DSP_C from LAT cycles earlier.
REQ-013 RES_VALID  out  1  result strobe, one cycle per operation; no backpressure.
REQ-014 RES_ID  out  IDW  requester index of the result.
REQ-015 RES_DATA  out  40  result value.

Function
REQ-016 Arithmetic: signed two's complement; result = A*B + C, truncated to 40 bits, wrapping on overflow.
REQ-017 The block holds one 40-bit accumulator ACC[i] and one busy flag BUSY[i] per requester.
REQ-018 Eligibility: requester i is eligible when REQ_VALID[i]=1 and not (op is MAC and BUSY[i]=1).
REQ-019 Arbitration: round-robin, searching from pointer PTR upward with wrap; at most one REQ_READY bit is high per cycle; REQ_READY[i] is high only when requester i is eligible.
REQ-020 After a grant to requester g, PTR becomes (g+1) mod NREQ; with no grant, PTR is unchanged.
REQ-021 Issue: a handshake in cycle t registers the operands into DSP_A/B/C with DSP_EN=1 in cycle t+1; with no handshake, DSP_EN=0 and DSP_A/B/C hold their values.
REQ-022 DSP_C is ACC[g] for MAC, and 0 for MUL, LOAD and reserved.
REQ-023 A tag pipeline of LAT+1 stages carries {valid, id, op} alongside each issue.
REQ-024 Completion: RES_VALID=1, RES_ID=g and RES_DATA=DSP_P (sampled in cycle t+1+LAT) are registered and appear in cycle t+2+LAT; total latency is LAT+2 = 5 cycles at the default.
REQ-025 On the edge that asserts RES_VALID: for MAC or LOAD, ACC[g] takes RES_DATA; MUL and reserved leave ACC unchanged.
REQ-026 BUSY[i] is set by any handshake of requester i and cleared on the edge that asserts RES_VALID for i; a set and a clear on the same edge leave BUSY=1.
REQ-027 A MAC from requester i can handshake in the cycle RES_VALID is high for i, and uses the updated ACC[i].
REQ-028 MUL and LOAD ignore BUSY, allowing back-to-back issue; a MAC stalls until every outstanding op of that requester has retired.
REQ-029 The reserved opcode (11) executes as MUL.
REQ-030 Maximum throughput is one issue per cycle across all requesters.

Reset
REQ-031 While SRST=1 the block forces REQ_READY=0, DSP_EN=0, DSP_A=DSP_B=0, DSP_C=0, RES_VALID=0, RES_ID=0, RES_DATA=0, all ACC=0, all BUSY=0, PTR=0 and all tag-pipeline valids to 0.
REQ-032 Reset mid-operation discards all in-flight operations: no RES_VALID appears for any issue made before reset, and DSP_P is ignored until a post-reset issue reaches its completion cycle.

Verification
REQ-033 Single MUL: requester 0 issues A=3, B=-4, op 00 in cycle 0 -> DSP_EN=1 in cycle 1; RES_VALID=1, RES_ID=0, RES_DATA=-12 in cycle 5; ACC[0] stays 0.
REQ-034 Accumulate chain: requester 1 issues LOAD 2*5, then MAC 3*3, MAC 1*1 -> each MAC waits for the previous retire; results are 10, 19, 20; ACC[1]=20.
REQ-035 Fairness: all 4 requesters hold MUL requests for 8 cycles -> grants run 0,1,2,3,0,1,2,3; each requester gets exactly 2.
REQ-036 Hazard bypass: requester 2 has a MAC in flight and requester 3 requests MUL -> requester 3 is granted immediately and requester 2's MAC is held off.
REQ-037 Wrap: ACC=0x7F_FFFF_FFFF, MAC 1*1 -> RES_DATA=0x80_0000_0000.
REQ-038 Reset mid-flight: SRST is pulsed 2 cycles after issue -> no RES_VALID follows, and ACC and BUSY read 0.
